// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with halt and counters
module core_sequencer #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 w_en_regfile,
   input  logic                 w_en_datamem,
   input  logic                 is_load,
   input  logic                 is_jump,
   input  logic                 is_branch,
   input  logic                 syscall_en,
   input  logic                 halt_req,
   input  logic                 resume,
   input  logic                 im_ack,
   input  logic                 dm_ack,
   output logic                 im_req,
   output logic                 ir_en,
   output logic                 dm_req,
   output logic                 dm_we,
   output logic                 rf_we,
   output logic                 pc_en,
   output logic                 halted,
   output logic [2:0]           state,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
   logic [CNT_WIDTH-1:0] instr_q, instr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_d;
         instr_q <= instr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      im_req  = 1'b0;
      ir_en   = 1'b0;
      dm_req  = 1'b0;
      dm_we   = 1'b0;
      rf_we   = 1'b0;
      pc_en   = 1'b0;
      halted  = 1'b0;
      case (state_q)
         S_FETCH: begin
            im_req = 1'b1;
            if (im_ack) begin
               ir_en   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (syscall_en && halt_req) begin
               state_d = S_HALT;
            end else if (syscall_en) begin
               state_d = S_WB;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_load || w_en_datamem) begin
               state_d = S_MEM;
            end else if ((is_jump || is_branch) && !w_en_regfile) begin
               pc_en   = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            dm_req = 1'b1;
            dm_we  = w_en_datamem;
            if (dm_ack) begin
               if (w_en_datamem) begin
                  pc_en   = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            rf_we   = w_en_regfile && !syscall_en;
            pc_en   = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
            if (resume) begin
               pc_en   = 1'b1;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
      // Reset silences every request and strobe in the very cycle it is asserted.
      if (rst) begin
         im_req = 1'b0;
         ir_en  = 1'b0;
         dm_req = 1'b0;
         dm_we  = 1'b0;
         rf_we  = 1'b0;
         pc_en  = 1'b0;
         halted = 1'b0;
      end
   end

   always_comb begin
      cycle_d = cycle_q;
      instr_d = instr_q;
      if (state_q != S_HALT) cycle_d = cycle_q + CNT_WIDTH'(1);
      if (pc_en) instr_d = instr_q + CNT_WIDTH'(1);
   end

   assign state       = rst ? 3'd0 : state_q;
   assign cycle_count = rst ? '0 : cycle_q;
   assign instr_count = rst ? '0 : instr_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - randomized self-checking bench for core_sequencer
module tb_core_sequencer;

   localparam int K_ALU = 0, K_JAL = 1, K_BR = 2, K_ST = 3, K_LD = 4, K_SYS = 5, K_HLT = 6;

   logic clk = 1'b0;
   logic rst, w_en_regfile, w_en_datamem, is_load, is_jump, is_branch;
   logic syscall_en, halt_req, resume, im_ack, dm_ack;
   logic im_req, ir_en, dm_req, dm_we, rf_we, pc_en, halted;
   logic [2:0]  state;
   logic [31:0] cycle_count, instr_count;

   int checks = 0;
   int failures = 0;
   logic [31:0] cyc_exp, ins_exp;
   logic [2:0] st_log[$];
   logic [6:0] str_log[$];

   always #5 clk = ~clk;

   core_sequencer #(.CNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .w_en_regfile(w_en_regfile), .w_en_datamem(w_en_datamem),
      .is_load(is_load), .is_jump(is_jump), .is_branch(is_branch),
      .syscall_en(syscall_en), .halt_req(halt_req), .resume(resume),
      .im_ack(im_ack), .dm_ack(dm_ack),
      .im_req(im_req), .ir_en(ir_en), .dm_req(dm_req), .dm_we(dm_we),
      .rf_we(rf_we), .pc_en(pc_en), .halted(halted), .state(state),
      .cycle_count(cycle_count), .instr_count(instr_count)
   );

   task automatic set_decoder(input int kind);
      w_en_regfile = 1'b0; w_en_datamem = 1'b0; is_load = 1'b0; is_jump = 1'b0;
      is_branch = 1'b0; syscall_en = 1'b0; halt_req = 1'b0;
      case (kind)
         K_ALU: w_en_regfile = 1'b1;
         K_JAL: begin is_jump = 1'b1; w_en_regfile = 1'b1; end
         K_BR:  if ($urandom_range(0, 1) == 1) is_jump = 1'b1; else is_branch = 1'b1;
         K_ST:  w_en_datamem = 1'b1;
         K_LD:  begin is_load = 1'b1; w_en_regfile = 1'b1; end
         K_SYS: begin syscall_en = 1'b1; w_en_regfile = 1'b1; end
         K_HLT: begin syscall_en = 1'b1; halt_req = 1'b1; w_en_regfile = 1'b1; end
         default: ;
      endcase
   endtask

   // Runs one instruction from its FETCH cycle through its pc_en cycle and checks it
   // against cycle/strobe totals derived from the per-class latency table.
   task automatic run_instr(input int kind, input int im_wait, input int dm_wait,
                            input int res_delay, input bit noise);
      int n_cyc, n_imreq, n_iren, n_dmreq, n_dmwe, n_rfwe, n_halt, im_cnt, dm_cnt;
      int base, e_nonhalt, e_total, e_dmreq, e_dmwe, e_rfwe, e_halt;
      bit done, mem_kind;
      logic [31:0] cyc_start;
      n_cyc = 0; n_imreq = 0; n_iren = 0; n_dmreq = 0; n_dmwe = 0; n_rfwe = 0;
      n_halt = 0; im_cnt = 0; dm_cnt = 0; done = 1'b0;
      cyc_start = cyc_exp;
      st_log.delete(); str_log.delete();
      set_decoder(kind);
      while (!done && n_cyc < 200) begin
         @(negedge clk);
         if (n_cyc == 0) begin
            checks++;
            if (cycle_count !== cyc_exp) begin
               failures++;
               $display("FAIL cycle_count_at_start kind=%0d: got %0d expected %0d", kind, cycle_count, cyc_exp);
            end
            checks++;
            if (instr_count !== ins_exp) begin
               failures++;
               $display("FAIL instr_count_at_start kind=%0d: got %0d expected %0d", kind, instr_count, ins_exp);
            end
         end
         im_ack = im_req ? (im_cnt == im_wait) : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
         dm_ack = dm_req ? (dm_cnt == dm_wait) : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
         if (halted) resume = (n_halt == res_delay);
         else        resume = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         #1;
         n_cyc++;
         st_log.push_back(state);
         str_log.push_back({im_req, ir_en, dm_req, dm_we, rf_we, pc_en, halted});
         if (im_req) n_imreq++;
         if (ir_en)  n_iren++;
         if (dm_req) n_dmreq++;
         if (dm_we)  n_dmwe++;
         if (rf_we)  n_rfwe++;
         if (halted) begin
            checks++;
            if (cycle_count !== cyc_start + 32'(2 + im_wait)) begin
               failures++;
               $display("FAIL cycle_count_frozen_in_halt: got %0d expected %0d", cycle_count, cyc_start + 32'(2 + im_wait));
            end
            n_halt++;
         end
         if (im_req && !im_ack) im_cnt++;
         if (dm_req && !dm_ack) dm_cnt++;
         if (pc_en) done = 1'b1;
         @(posedge clk);
      end
      #1;
      im_ack = 1'b0; dm_ack = 1'b0; resume = 1'b0;

      mem_kind = (kind == K_ST || kind == K_LD);
      case (kind)
         K_ALU, K_JAL, K_ST: base = 4;
         K_BR, K_SYS:        base = 3;
         K_LD:               base = 5;
         default:            base = 2;
      endcase
      e_nonhalt = base + im_wait + (mem_kind ? dm_wait : 0);
      e_halt    = (kind == K_HLT) ? res_delay + 1 : 0;
      e_total   = e_nonhalt + e_halt;
      e_dmreq   = mem_kind ? dm_wait + 1 : 0;
      e_dmwe    = (kind == K_ST) ? dm_wait + 1 : 0;
      e_rfwe    = (kind == K_ALU || kind == K_JAL || kind == K_LD) ? 1 : 0;

      checks++;
      if (!done) begin
         failures++;
         $display("FAIL pc_en_timeout kind=%0d: got no pc_en within %0d cycles expected one", kind, n_cyc);
      end
      checks++;
      if (n_cyc != e_total) begin failures++; $display("FAIL total_cycles kind=%0d: got %0d expected %0d", kind, n_cyc, e_total); end
      checks++;
      if (n_imreq != im_wait + 1) begin failures++; $display("FAIL im_req_cycles kind=%0d: got %0d expected %0d", kind, n_imreq, im_wait + 1); end
      checks++;
      if (n_iren != 1) begin failures++; $display("FAIL ir_en_pulses kind=%0d: got %0d expected 1", kind, n_iren); end
      checks++;
      if (n_dmreq != e_dmreq) begin failures++; $display("FAIL dm_req_cycles kind=%0d: got %0d expected %0d", kind, n_dmreq, e_dmreq); end
      checks++;
      if (n_dmwe != e_dmwe) begin failures++; $display("FAIL dm_we_cycles kind=%0d: got %0d expected %0d", kind, n_dmwe, e_dmwe); end
      checks++;
      if (n_rfwe != e_rfwe) begin failures++; $display("FAIL rf_we_pulses kind=%0d: got %0d expected %0d", kind, n_rfwe, e_rfwe); end
      checks++;
      if (n_halt != e_halt) begin failures++; $display("FAIL halted_cycles kind=%0d: got %0d expected %0d", kind, n_halt, e_halt); end
      cyc_exp = cyc_exp + 32'(e_nonhalt);
      ins_exp = ins_exp + 32'd1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         set_decoder($urandom_range(0, 6));
         im_ack = 1'($urandom_range(0, 1)); dm_ack = 1'($urandom_range(0, 1));
         resume = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if ({im_req, ir_en, dm_req, dm_we, rf_we, pc_en, halted} !== 7'd0 || state !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs: got strobes=%b state=%0d expected 0", {im_req, ir_en, dm_req, dm_we, rf_we, pc_en, halted}, state);
         end
         checks++;
         if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_count, instr_count);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0; im_ack = 1'b0; dm_ack = 1'b0; resume = 1'b0;
      #1;
      checks++;
      if (im_req !== 1'b1 || state !== 3'd0) begin
         failures++;
         $display("FAIL first_fetch_after_reset: got im_req=%b state=%0d expected 1/0", im_req, state);
      end
      cyc_exp = 32'd0;
      ins_exp = 32'd0;
   endtask

   task automatic test_addu();
      logic [2:0] e_st [4];
      logic [6:0] e_str[4];
      e_st  = '{3'd0, 3'd1, 3'd2, 3'd4};
      e_str = '{7'b1100000, 7'b0000000, 7'b0000000, 7'b0000110};
      run_instr(K_ALU, 0, 0, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (st_log.size() <= i || st_log[i] !== e_st[i] || str_log[i] !== e_str[i]) begin
            failures++;
            $display("FAIL addu_cycle%0d: got state=%0d strobes=%b expected state=%0d strobes=%b",
                     i, (st_log.size() > i) ? st_log[i] : 3'd7, (str_log.size() > i) ? str_log[i] : 7'h7f, e_st[i], e_str[i]);
         end
      end
   endtask

   task automatic test_store();
      run_instr(K_ST, 0, 0, 0, 1'b0);
      checks++;
      if (str_log.size() != 4 || str_log[3] !== 7'b0011010) begin
         failures++;
         $display("FAIL sw_mem_cycle: got strobes=%b expected 0011010", (str_log.size() > 3) ? str_log[3] : 7'h7f);
      end
   endtask

   task automatic test_load_wait();
      run_instr(K_LD, 0, 3, 0, 1'b0);
   endtask

   task automatic test_branch_jal();
      run_instr(K_BR, 0, 0, 0, 1'b0);
      run_instr(K_JAL, 0, 0, 0, 1'b0);
   endtask

   task automatic test_halt();
      run_instr(K_HLT, 2, 0, 10, 1'b1);
      run_instr(K_HLT, 0, 0, 0, 1'b1);
      run_instr(K_SYS, 1, 0, 0, 1'b1);
   endtask

   task automatic test_reset_mid_mem();
      int mem_seen, guard;
      bit hit;
      mem_seen = 0; guard = 0; hit = 1'b0;
      set_decoder(K_LD);
      while (!hit && guard < 20) begin
         @(negedge clk);
         guard++;
         if (mem_seen == 1) begin
            rst = 1'b1; im_ack = 1'b1;
            #1;
            hit = 1'b1;
            checks++;
            if (dm_req !== 1'b0 || rf_we !== 1'b0 || pc_en !== 1'b0 || state !== 3'd0) begin
               failures++;
               $display("FAIL reset_in_mem: got dm_req=%b rf_we=%b pc_en=%b state=%0d expected 0/0/0/0", dm_req, rf_we, pc_en, state);
            end
            checks++;
            if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin
               failures++;
               $display("FAIL reset_in_mem_counters: got %0d/%0d expected 0/0", cycle_count, instr_count);
            end
         end else begin
            im_ack = im_req; dm_ack = 1'b0;
            #1;
            if (dm_req) mem_seen++;
         end
         @(posedge clk);
      end
      checks++;
      if (!hit) begin failures++; $display("FAIL reset_in_mem_reach: got no MEM cycle expected one within 20 cycles"); end
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         im_ack = 1'b0; dm_ack = 1'b1;
         #1;
         checks++;
         if (state !== 3'd0 || im_req !== 1'b1 || dm_req !== 1'b0 || rf_we !== 1'b0 || pc_en !== 1'b0) begin
            failures++;
            $display("FAIL late_dm_ack_ignored: got state=%0d im_req=%b dm_req=%b rf_we=%b pc_en=%b expected 0/1/0/0/0",
                     state, im_req, dm_req, rf_we, pc_en);
         end
         @(posedge clk);
      end
      #1;
      dm_ack = 1'b0;
      cyc_exp = 32'd3;
      ins_exp = 32'd0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         run_instr($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      end
   endtask

   initial begin
      rst = 1'b1; im_ack = 1'b0; dm_ack = 1'b0; resume = 1'b0;
      set_decoder(K_ALU);
      cyc_exp = 32'd0; ins_exp = 32'd0;
      test_reset();
      test_addu();
      test_load_wait();
      test_store();
      test_branch_jal();
      test_halt();
      test_reset_mid_mem();
      test_random();
      @(negedge clk);
      checks++;
      if (cycle_count !== cyc_exp || instr_count !== ins_exp) begin
         failures++;
         $display("FAIL final_counters: got %0d/%0d expected %0d/%0d", cycle_count, instr_count, cyc_exp, ins_exp);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the Laji core. It sits between the combinational instruction decoder and the datapath registers, and steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It gates every architectural write enable (PC, IR, register file, data memory) to a single cycle, and handles variable-latency instruction and data memory through req/ack handshakes. It also implements syscall halt/resume and keeps cycle and retired-instruction counters for the display logic.

## Interface

- CNT_WIDTH, 32, width of `cycle_count` and `instr_count`
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- w_en_regfile  in  1  decoder: instruction writes the register file
- w_en_datamem  in  1  decoder: instruction is a store
- is_load  in  1  decoder: instruction reads data memory (lb/lh/lw/lbu/lhu)
- is_jump  in  1  decoder: j/jal/jr
- is_branch  in  1  decoder: beq/bne/blez/bgtz/bltz/bgez
- syscall_en  in  1  decoder: syscall
- halt_req  in  1  datapath: syscall operand requests halt ($v0 == 10)
- resume  in  1  single-cycle pulse from the debounced "go" button
- im_ack  in  1  instruction memory: data valid this cycle
- dm_ack  in  1  data memory: access complete this cycle
- im_req  out  1  instruction fetch request
- ir_en  out  1  load instruction register
- dm_req  out  1  data memory request
- dm_we  out  1  data memory write strobe
- rf_we  out  1  register file write strobe
- pc_en  out  1  PC update; marks instruction retirement
- halted  out  1  core is in HALT
- state  out  3  current state, for debug
- cycle_count  out  CNT_WIDTH  cycles spent outside HALT since reset
- instr_count  out  CNT_WIDTH  retired instructions since reset

## Operation

- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 return to FETCH on the next cycle, with all strobes 0.
- Outputs are combinational from the state register and the decoder inputs. The decoder inputs are driven from IR, so they are stable from DECODE through WB.
- FETCH: `im_req`=1.
  - On `im_ack`: `ir_en`=1 for that cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle.
  - `syscall_en && halt_req`: go to HALT.
  - `syscall_en && !halt_req`: go to WB.
  - Otherwise: go to EXEC.
- EXEC: one cycle.
  - `is_load || w_en_datamem`: go to MEM.
  - `(is_jump || is_branch) && !w_en_regfile`: `pc_en`=1, go to FETCH.
  - Otherwise (including jal): go to WB.
- MEM: `dm_req`=1, and `dm_we` = `w_en_datamem` for the whole state.
  - On `dm_ack` with a store: `pc_en`=1, go to FETCH.
  - On `dm_ack` with a load: go to WB.
  - No ack: hold.
- WB: one cycle. `rf_we` = `w_en_regfile && !syscall_en`, `pc_en`=1, go to FETCH.
- HALT: `halted`=1, all strobes 0.
  - On `resume`: `pc_en`=1 (step past the syscall), go to FETCH.
  - `resume` outside HALT is ignored.
- `ir_en`, `pc_en`, `rf_we` and `dm_we` are never high outside the states listed above. At most one `pc_en` pulse occurs per instruction.
- `cycle_count` increments every cycle with state != HALT and rst=0. `instr_count` increments on every `pc_en`. Both wrap modulo 2^CNT_WIDTH silently.

## Timing

- Reset: while rst=1, state=FETCH, both counters are 0, and all outputs are 0 (`im_req` is forced 0 during reset). On the first cycle after rst falls, `im_req`=1.
- Reset takes effect at any state, including a pending MEM or FETCH handshake. The outstanding request drops in the reset cycle and is not reissued until FETCH. Memory acks during reset are ignored.
- Zero-wait memory (ack in the first cycle of `req`) gives these cycles per instruction:
  - ALU or jal: 4
  - branch/jump without write: 3
  - store: 4
  - load: 5
  - non-halting syscall: 3
- Each extra wait cycle on `im_ack`/`dm_ack` adds exactly one cycle. `im_req`/`dm_req` stay high continuously until the ack cycle, inclusive, and drop the next cycle.
- An ack in any state other than the matching FETCH/MEM is ignored.
- `halted` rises in the first HALT cycle. A `resume` in that same cycle is honoured.
- The `cycle_count` increment for the DECODE cycle that enters HALT is counted. HALT cycles are not counted.

## Test plan

- Reset, then addu with im_ack tied 1: states 0,1,2,4,0. `ir_en` in cycle 1, `rf_we`=`pc_en`=1 in cycle 4, `instr_count`=1, `cycle_count`=4.
- lw with dm_ack delayed 3 cycles: MEM lasts 4 cycles with `dm_req` high and `dm_we`=0 throughout, then one WB cycle with `rf_we`=1. Total 8 cycles.
- sw with zero-wait memory: `dm_req`=`dm_we`=`pc_en`=1 in the single MEM cycle, `rf_we` never asserted, next state FETCH. CPI 4.
- beq then jal: beq retires in EXEC (CPI 3, no `rf_we`). jal passes through WB with `rf_we`=1 (CPI 4). `instr_count`=2.
- syscall with halt_req=1: HALT after DECODE, `halted`=1, `cycle_count` frozen for 10 cycles. A `resume` pulse gives `pc_en`=1 and returns to FETCH. A `resume` pulsed earlier in FETCH has no effect.
- Assert rst for 1 cycle during the second MEM wait cycle of lw: `dm_req` is 0 in that cycle, no `rf_we`/`pc_en`, state=FETCH, counters=0. A late `dm_ack` after reset is ignored.
